// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared constants, state encoding and pointer helper for the round-robin mux arbiter
package mux_arb_pkg;
    localparam int NUM_REQ = 4;
    localparam int SEL_W = 2;
    typedef enum logic {IDLE, GRANT} state_t;
    function automatic logic [SEL_W-1:0] nxt(input logic [SEL_W-1:0] p);
        return p + SEL_W'(1);
    endfunction
endpackage

// File: rtl/mux.sv
// mux: 4:1 one-bit datapath mux, o = i[s]
module mux (
    input  logic [3:0] i,
    input  logic [1:0] s,
    output logic       o
);
    assign o = i[s];
endmodule

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rr_pick: rotated-priority search for the first active request starting at ptr
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);
    logic [SEL_W-1:0] j;
    // Scan from farthest to nearest so the closest active request to ptr wins
    always_comb begin
        found = 1'b0;
        idx = '0;
        j = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = ptr + SEL_W'(k);
            if (req[j]) begin
                found = 1'b1;
                idx = j;
            end
        end
    end
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter sequencing the mux select with bounded tenures and a registered output
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] i,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   s,
    output logic               busy,
    output logic               o,
    output logic               o_valid
);
    state_t state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] s_q, s_d, ptr_q, ptr_d, pick_idx;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic o_q, o_d, o_valid_q, o_valid_d, pick_found, mux_o;

    rr_pick u_pick (.req(req), .ptr(ptr_q), .found(pick_found), .idx(pick_idx));
    mux u_mux (.i(i), .s(s_q), .o(mux_o));

    always_comb begin
        state_d = state_q;
        gnt_d = gnt_q;
        s_d = s_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        o_d = (state_q == GRANT) ? mux_o : o_q;
        o_valid_d = (state_q == GRANT);
        if (state_q == IDLE) begin
            if (pick_found) begin
                state_d = GRANT;
                gnt_d = NUM_REQ'(1) << pick_idx;
                s_d = pick_idx;
                cnt_d = '0;
            end
        end else if (!req[s_q] || cnt_q == CNT_W'(MAX_HOLD - 1)) begin
            // Release always passes through IDLE, giving the mandatory bubble
            state_d = IDLE;
            gnt_d = '0;
            ptr_d = nxt(s_q);
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q <= '0;
            s_q <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
            o_q <= 1'b0;
            o_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q <= gnt_d;
            s_q <= s_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            o_q <= o_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign gnt = gnt_q;
    assign s = s_q;
    assign busy = (state_q == GRANT);
    assign o = o_q;
    assign o_valid = o_valid_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: randomized and directed scoreboard bench against a behavioural arbitration model
module tb_mux_rr_arbiter;
    localparam int MAX_HOLD = 4;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] s;
        logic       busy;
        logic       o;
        logic       ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] i = '0;
    logic [3:0] gnt;
    logic [1:0] s;
    logic busy, o, o_valid;

    exp_t exp_q[$];
    int n_chk = 0;
    int n_fail = 0;
    int run_len = 0;

    int m_owner = -1;
    int m_ptr = 0;
    int m_held = 0;
    int m_sel = 0;
    logic m_o = 1'b0;
    logic m_ov = 1'b0;

    mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .i(i),
        .gnt(gnt), .s(s), .busy(busy), .o(o), .o_valid(o_valid)
    );

    always #5 clk = ~clk;

    // Drive one edge worth of inputs and record what the outputs must be after it
    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] d);
        exp_t e;
        @(negedge clk);
        rst = r;
        req = rq;
        i = d;
        if (r) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_sel = 0; m_o = 1'b0; m_ov = 1'b0;
        end else begin
            m_ov = (m_owner >= 0);
            if (m_owner >= 0) begin
                m_o = d[m_owner];
                m_held++;
                if (!rq[m_owner] || m_held == MAX_HOLD) begin
                    m_ptr = (m_owner + 1) % 4;
                    m_owner = -1;
                end
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (m_owner < 0 && rq[(m_ptr + k) % 4]) begin
                        m_owner = (m_ptr + k) % 4;
                        m_sel = m_owner;
                        m_held = 0;
                    end
                end
            end
        end
        e.gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        e.s = 2'(m_sel);
        e.busy = (m_owner >= 0);
        e.o = m_o;
        e.ov = m_ov;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (gnt !== e.gnt || s !== e.s || busy !== e.busy || o_valid !== e.ov) begin
                n_fail++;
                $display("FAIL ctrl t=%0t got gnt=%b s=%0d busy=%b ov=%b exp gnt=%b s=%0d busy=%b ov=%b",
                         $time, gnt, s, busy, o_valid, e.gnt, e.s, e.busy, e.ov);
            end
            n_chk++;
            if (o !== e.o) begin
                n_fail++;
                $display("FAIL data t=%0t got o=%b exp o=%b (ov=%b)", $time, o, e.o, e.ov);
            end
            run_len = (busy === 1'b1) ? run_len + 1 : 0;
            n_chk++;
            if (run_len > MAX_HOLD) begin
                n_fail++;
                $display("FAIL hold t=%0t got run=%0d exp max=%0d", $time, run_len, MAX_HOLD);
            end
        end
    end

    initial begin
        logic [3:0] rq;
        step(1, 4'b0000, 4'b0000);
        step(1, 4'b0000, 4'b0000);
        for (int k = 0; k < 3; k++) step(0, 4'b0100, 4'b0100);
        for (int k = 0; k < 2; k++) step(0, 4'b0000, 4'b0100);
        for (int k = 0; k < 12; k++) step(0, 4'b0101, 4'(k));
        for (int k = 0; k < 25; k++) step(0, 4'b1111, 4'(k * 7));
        for (int k = 0; k < 12; k++) step(0, 4'b0010, 4'(k * 3));
        for (int k = 0; k < 3; k++) step(0, 4'b0001, 4'b0001);
        step(1, 4'b0001, 4'b0001);
        for (int k = 0; k < 3; k++) step(0, 4'b0001, 4'b0000);
        step(0, 4'b0000, 4'b0000);
        step(0, 4'b1000, 4'b0000);
        step(0, 4'b1000, 4'b1000);
        step(0, 4'b1000, 4'b0000);
        step(0, 4'b1000, 4'b1000);
        for (int k = 0; k < 3; k++) step(0, 4'b0000, 4'(k * 5));
        rq = 4'b0000;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
            step(($urandom_range(0, 59) == 0), rq, 4'($urandom));
        end
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
